// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared definitions for the branch/load/mult-div hazard
//                controller: FSM state encoding, register-zero constant and
//                the producer/consumer register match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MDWAIT  = 2'd2
  } state_e;

  // Register 0 is hard-wired to zero and never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Extra stall cycles after the detect cycle for a branch behind an EX load.
  localparam logic [1:0] LD_STALL_INIT = 2'd1;

  // A producer matters only if it writes a nonzero register read by ID.
  function automatic logic src_match(input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd,
                                     input logic       we);
    return we && (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_hazard_ctrl_md_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : md_watchdog
//  Description : Saturating cycle counter that flags when a mult/div
//                operation has been outstanding for MD_TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_watchdog #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              W     = (MD_TIMEOUT < 1) ? 1 : $clog2(MD_TIMEOUT + 1);
  localparam logic [W-1:0]    LIMIT = W'(MD_TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_hazard_ctrl
//  Description : Pipeline hazard controller for ID-stage branches, load-use
//                dependencies and multi-cycle mult/div operations. Stalls are
//                combinational (same-cycle) and driven from a 3-state FSM.
//                Optional macro HAZARD_PERF_CNT_EN adds a saturating 32-bit
//                stall_cycles performance counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_is_branch,
  input  logic        id_is_md,
  input  logic [4:0]  ex_rd,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rd,
  input  logic        mem_we,
  input  logic        mem_is_load,
  input  logic        branch_taken,
  input  logic        md_done,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_go,
  output logic        md_err,
  output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       md_err_q, md_err_d;
  logic       ex_hit, mem_hit, hz1, hz2;
  logic       stall, md_go_w, wd_clear, wd_en, wd_expired;

  // Hazard detection against the EX and MEM producers.
  always_comb begin
    ex_hit  = src_match(id_rs, id_rt, ex_rd, ex_we);
    mem_hit = src_match(id_rs, id_rt, mem_rd, mem_we);
    hz2     = id_is_branch & ex_hit & ex_is_load;
    hz1     = (id_is_branch & mem_hit & mem_is_load) |
              (~id_is_branch & ex_hit & ex_is_load);
  end

  // Next-state and stall decision; load hazards outrank mult/div start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_err_d = md_err_q;
    stall    = 1'b0;
    md_go_w  = 1'b0;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz2) begin
          stall   = 1'b1;
          cnt_d   = LD_STALL_INIT;
          state_d = ST_LDSTALL;
        end else if (hz1) begin
          stall = 1'b1;
        end else if (id_is_md) begin
          stall    = 1'b1;
          md_go_w  = 1'b1;
          wd_clear = 1'b1;
          state_d  = ST_MDWAIT;
        end
      end
      ST_LDSTALL: begin
        if (cnt_q != 2'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MDWAIT: begin
        if (md_done) begin
          state_d = ST_RUN;
        end else if (wd_expired) begin
          md_err_d = 1'b1;
          state_d  = ST_RUN;
        end else begin
          stall = 1'b1;
          wd_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // FSM, load-stall counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= 2'd0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      md_err_q <= md_err_d;
    end
  end

  md_watchdog #(
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_md_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign pc_we      = ~stall;
  assign ifid_we    = ~stall;
  assign idex_flush = stall;
  assign ifid_flush = ~stall & id_is_branch & branch_taken;
  // Start pulse is suppressed while reset is held.
  assign md_go      = md_go_w & rst_n;
  assign md_err     = md_err_q;
  assign state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of stall cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire
